// File: rtl/nav_bit_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : nav_bit_sync
//  Purpose  : Navigation-bit synchroniser. Builds a 20-bin histogram of
//             prompt-I sign transitions indexed by millisecond phase, declares
//             bit sync when one bin reaches SYNC_THRESHOLD, then integrates
//             20 prompt dumps per nav bit and emits hard bit + soft sum.
//  Ports    : clk            - system clock
//             global_reset_n - asynchronous active-low reset
//             channel_reset  - synchronous clear back to SEARCH
//             tracking_ready - 1-cycle strobe, i_prompt_k valid
//             i_prompt_k     - signed 1 ms prompt-I accumulation
//             bit_sync       - 1 while LOCKED
//             bit_phase      - ms index (0..19) at which each nav bit starts
//             nav_bit_valid  - 1-cycle strobe, nav_bit/bit_sum valid
//             nav_bit        - hard decision, 1 when bit_sum >= 0
//             bit_sum        - signed sum of the 20 dumps of the last bit
//             sync_fail      - 1-cycle pulse on search timeout
//  Revision : 1.0 - initial release
// ============================================================================
module nav_bit_sync #(
    parameter int ACC_WIDTH         = 16,
    parameter int HIST_WIDTH        = 6,
    parameter int SYNC_THRESHOLD    = 8,
    parameter int SEARCH_TIMEOUT_MS = 2000
) (
    input  logic                        clk,
    input  logic                        global_reset_n,
    input  logic                        channel_reset,
    input  logic                        tracking_ready,
    input  logic signed [ACC_WIDTH-1:0] i_prompt_k,
    output logic                        bit_sync,
    output logic [4:0]                  bit_phase,
    output logic                        nav_bit_valid,
    output logic                        nav_bit,
    output logic signed [ACC_WIDTH+4:0] bit_sum,
    output logic                        sync_fail
);

    localparam int SUM_WIDTH = ACC_WIDTH + 5;
    localparam int TO_WIDTH  = $clog2(SEARCH_TIMEOUT_MS + 1);
    localparam int NUM_BINS  = 20;

    localparam logic [HIST_WIDTH-1:0] HIST_MAX = '1;
    localparam logic [HIST_WIDTH-1:0] HIST_THR = HIST_WIDTH'(SYNC_THRESHOLD);
    localparam logic [TO_WIDTH-1:0]   TO_LAST  = TO_WIDTH'(SEARCH_TIMEOUT_MS);
    localparam logic [4:0]            MS_LAST  = 5'd19;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                       state_q;
    logic [4:0]                   ms_index_q;
    logic                         prev_valid_q;
    logic                         prev_sign_q;
    logic [HIST_WIDTH-1:0]        hist_q [NUM_BINS];
    logic [TO_WIDTH-1:0]          timeout_q;
    logic signed [SUM_WIDTH-1:0]  bit_acc_q;
    logic                         bit_sync_q;
    logic [4:0]                   bit_phase_q;
    logic                         nav_bit_valid_q;
    logic                         nav_bit_q;
    logic signed [SUM_WIDTH-1:0]  bit_sum_q;
    logic                         sync_fail_q;

    // ------------------------------------------------------------------------
    // Next-value helpers
    // ------------------------------------------------------------------------
    logic                         sign_d;
    logic [4:0]                   ms_index_d;
    logic                         flip_d;
    logic [HIST_WIDTH-1:0]        bin_d;
    logic                         lock_d;
    logic [TO_WIDTH-1:0]          timeout_d;
    logic                         timeout_hit_d;
    logic signed [SUM_WIDTH-1:0]  sample_ext_d;
    logic signed [SUM_WIDTH-1:0]  acc_sum_d;
    logic [4:0]                   last_ms_d;

    always_comb begin
        // Zero has MSB 0 and therefore counts as a positive sample.
        sign_d        = i_prompt_k[ACC_WIDTH-1];
        ms_index_d    = (ms_index_q == MS_LAST) ? 5'd0 : ms_index_q + 5'd1;
        flip_d        = prev_valid_q && (sign_d != prev_sign_q);
        // Saturating bin increment: a full bin never wraps back to zero.
        bin_d         = (hist_q[ms_index_q] == HIST_MAX) ? hist_q[ms_index_q]
                                                         : hist_q[ms_index_q] + 1'b1;
        lock_d        = flip_d && (bin_d == HIST_THR);
        timeout_d     = timeout_q + 1'b1;
        timeout_hit_d = (timeout_d == TO_LAST);
        sample_ext_d  = {{5{i_prompt_k[ACC_WIDTH-1]}}, i_prompt_k};
        acc_sum_d     = bit_acc_q + sample_ext_d;
        // Last ms of a bit is the one just before the bit start phase.
        last_ms_d     = (bit_phase_q == 5'd0) ? MS_LAST : bit_phase_q - 5'd1;
    end

    // ------------------------------------------------------------------------
    // State machine and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q         <= ST_SEARCH;
            ms_index_q      <= 5'd0;
            prev_valid_q    <= 1'b0;
            prev_sign_q     <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) hist_q[i] <= '0;
            timeout_q       <= '0;
            bit_acc_q       <= '0;
            bit_sync_q      <= 1'b0;
            bit_phase_q     <= 5'd0;
            nav_bit_valid_q <= 1'b0;
            nav_bit_q       <= 1'b0;
            bit_sum_q       <= '0;
            sync_fail_q     <= 1'b0;
        end else if (channel_reset) begin
            // Re-acquisition discards everything, including a coincident strobe.
            state_q         <= ST_SEARCH;
            ms_index_q      <= 5'd0;
            prev_valid_q    <= 1'b0;
            prev_sign_q     <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) hist_q[i] <= '0;
            timeout_q       <= '0;
            bit_acc_q       <= '0;
            bit_sync_q      <= 1'b0;
            bit_phase_q     <= 5'd0;
            nav_bit_valid_q <= 1'b0;
            nav_bit_q       <= 1'b0;
            bit_sum_q       <= '0;
            sync_fail_q     <= 1'b0;
        end else begin
            nav_bit_valid_q <= 1'b0;
            sync_fail_q     <= 1'b0;
            if (tracking_ready) begin
                ms_index_q <= ms_index_d;
                case (state_q)
                    ST_SEARCH: begin
                        prev_sign_q  <= sign_d;
                        prev_valid_q <= 1'b1;
                        if (flip_d) hist_q[ms_index_q] <= bin_d;
                        if (lock_d) begin
                            // Lock has priority over a simultaneous timeout; the
                            // locking sample opens the first bit.
                            state_q     <= ST_LOCKED;
                            bit_sync_q  <= 1'b1;
                            bit_phase_q <= ms_index_q;
                            bit_acc_q   <= sample_ext_d;
                        end else if (timeout_hit_d) begin
                            sync_fail_q  <= 1'b1;
                            timeout_q    <= '0;
                            prev_valid_q <= 1'b0;
                            for (int i = 0; i < NUM_BINS; i++) hist_q[i] <= '0;
                        end else begin
                            timeout_q <= timeout_d;
                        end
                    end
                    ST_LOCKED: begin
                        if (ms_index_q == last_ms_d) begin
                            nav_bit_valid_q <= 1'b1;
                            bit_sum_q       <= acc_sum_d;
                            nav_bit_q       <= ~acc_sum_d[SUM_WIDTH-1];
                            bit_acc_q       <= '0;
                        end else begin
                            bit_acc_q <= acc_sum_d;
                        end
                    end
                    default: state_q <= ST_SEARCH;
                endcase
            end
        end
    end

    assign bit_sync      = bit_sync_q;
    assign bit_phase     = bit_phase_q;
    assign nav_bit_valid = nav_bit_valid_q;
    assign nav_bit       = nav_bit_q;
    assign bit_sum       = bit_sum_q;
    assign sync_fail     = sync_fail_q;

endmodule
`default_nettype wire
